// File: rtl/sdram_arbiter.sv
// Two-port (CPU / video) arbiter and half-word sequencer in front of the 16-bit SDRAM controller.
// Each 32-bit access becomes one or two fixed-length slots; the owner gets a one-cycle ready.
module sdram_arbiter #(
    parameter int SLOT_CYCLES = 8,
    parameter int ADDR_BITS   = 24
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cpu_valid,
    output logic                 cpu_ready,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [3:0]           cpu_wstrb,
    input  logic [31:0]          cpu_wdata,
    output logic [31:0]          cpu_rdata,
    input  logic                 vid_valid,
    output logic                 vid_ready,
    input  logic [ADDR_BITS-1:0] vid_addr,
    output logic [31:0]          vid_rdata,
    output logic [ADDR_BITS-1:0] sd_addr,
    output logic                 sd_we,
    output logic                 sd_oe,
    output logic [1:0]           sd_be,
    output logic [15:0]          sd_din,
    input  logic [15:0]          sd_dout,
    output logic                 grant,
    output logic                 busy
);
    localparam int CW = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state_r, state_s;
    logic [CW-1:0]          cnt_r, cnt_s;
    logic                   last_r, last_s;
    logic                   grant_r, grant_s;
    logic [ADDR_BITS-3:0]   waddr_r, waddr_s;
    logic [3:0]             wstrb_r, wstrb_s;
    logic [31:0]            wdata_r, wdata_s;
    logic [31:0]            rdata_r, rdata_s;
    logic [ADDR_BITS-1:0]   sd_addr_r, sd_addr_s;
    logic                   sd_we_r, sd_we_s;
    logic                   sd_oe_r, sd_oe_s;
    logic [1:0]             sd_be_r, sd_be_s;
    logic [15:0]            sd_din_r, sd_din_s;
    logic                   cpu_ready_r, cpu_ready_s;
    logic                   vid_ready_r, vid_ready_s;
    logic                   busy_r, busy_s;
    logic                   unused_addr_lsb;

    assign unused_addr_lsb = ^{cpu_addr[1:0], vid_addr[1:0]};

    // Arbitration, slot sequencing and next values of every registered output.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        last_s    = last_r;
        grant_s   = grant_r;
        waddr_s   = waddr_r;
        wstrb_s   = wstrb_r;
        wdata_s   = wdata_r;
        rdata_s   = rdata_r;
        case (state_r)
            IDLE: begin
                cnt_s = {CW{1'b0}};
                if (cpu_valid && (!vid_valid || last_r)) begin
                    grant_s = 1'b0;
                    last_s  = 1'b0;
                    waddr_s = cpu_addr[ADDR_BITS-1:2];
                    wstrb_s = cpu_wstrb;
                    wdata_s = cpu_wdata;
                    // A write that leaves the low half untouched skips the LO slot.
                    if ((cpu_wstrb[1:0] == 2'b00) && (cpu_wstrb[3:2] != 2'b00)) begin
                        state_s = HI;
                    end else begin
                        state_s = LO;
                    end
                end else if (vid_valid) begin
                    grant_s = 1'b1;
                    last_s  = 1'b1;
                    waddr_s = vid_addr[ADDR_BITS-1:2];
                    wstrb_s = 4'b0000;
                    wdata_s = 32'h0000_0000;
                    state_s = LO;
                end else begin
                    state_s = IDLE;
                end
            end
            LO: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s = {CW{1'b0}};
                    if (wstrb_r == 4'b0000) begin
                        rdata_s[15:0] = sd_dout;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    if ((wstrb_r != 4'b0000) && (wstrb_r[3:2] == 2'b00)) begin
                        state_s = DONE;
                    end else begin
                        state_s = HI;
                    end
                end else begin
                    state_s = LO;
                end
            end
            HI: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s = {CW{1'b0}};
                    if (wstrb_r == 4'b0000) begin
                        rdata_s[31:16] = sd_dout;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    state_s = DONE;
                end else begin
                    state_s = HI;
                end
            end
            DONE: begin
                cnt_s   = {CW{1'b0}};
                state_s = IDLE;
            end
            default: begin
                cnt_s   = {CW{1'b0}};
                state_s = IDLE;
            end
        endcase

        // Outputs are computed from the upcoming state so they line up with it once registered.
        sd_addr_s = sd_addr_r;
        sd_din_s  = sd_din_r;
        sd_we_s   = 1'b0;
        sd_oe_s   = 1'b0;
        sd_be_s   = 2'b00;
        case (state_s)
            LO: begin
                sd_addr_s = {waddr_s, 2'b00};
                if (wstrb_s == 4'b0000) begin
                    sd_oe_s = 1'b1;
                    sd_be_s = 2'b11;
                end else begin
                    sd_we_s  = 1'b1;
                    sd_be_s  = wstrb_s[1:0];
                    sd_din_s = wdata_s[15:0];
                end
            end
            HI: begin
                sd_addr_s = {waddr_s, 2'b10};
                if (wstrb_s == 4'b0000) begin
                    sd_oe_s = 1'b1;
                    sd_be_s = 2'b11;
                end else begin
                    sd_we_s  = 1'b1;
                    sd_be_s  = wstrb_s[3:2];
                    sd_din_s = wdata_s[31:16];
                end
            end
            default: begin
                sd_we_s = 1'b0;
            end
        endcase
        cpu_ready_s = (state_s == DONE) && !grant_s;
        vid_ready_s = (state_s == DONE) && grant_s;
        busy_s      = (state_s != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            last_r      <= 1'b1;
            grant_r     <= 1'b0;
            waddr_r     <= {(ADDR_BITS-2){1'b0}};
            wstrb_r     <= 4'b0000;
            wdata_r     <= 32'h0000_0000;
            rdata_r     <= 32'h0000_0000;
            sd_addr_r   <= {ADDR_BITS{1'b0}};
            sd_we_r     <= 1'b0;
            sd_oe_r     <= 1'b0;
            sd_be_r     <= 2'b00;
            sd_din_r    <= 16'h0000;
            cpu_ready_r <= 1'b0;
            vid_ready_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            last_r      <= last_s;
            grant_r     <= grant_s;
            waddr_r     <= waddr_s;
            wstrb_r     <= wstrb_s;
            wdata_r     <= wdata_s;
            rdata_r     <= rdata_s;
            sd_addr_r   <= sd_addr_s;
            sd_we_r     <= sd_we_s;
            sd_oe_r     <= sd_oe_s;
            sd_be_r     <= sd_be_s;
            sd_din_r    <= sd_din_s;
            cpu_ready_r <= cpu_ready_s;
            vid_ready_r <= vid_ready_s;
            busy_r      <= busy_s;
        end
    end

    assign cpu_ready = cpu_ready_r;
    assign vid_ready = vid_ready_r;
    assign cpu_rdata = rdata_r;
    assign vid_rdata = rdata_r;
    assign sd_addr   = sd_addr_r;
    assign sd_we     = sd_we_r;
    assign sd_oe     = sd_oe_r;
    assign sd_be     = sd_be_r;
    assign sd_din    = sd_din_r;
    assign grant     = grant_r;
    assign busy      = busy_r;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small half-word memory standing in for the controller.
module tb_sdram_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_valid, cpu_ready;
    logic [23:0] cpu_addr;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        vid_valid, vid_ready;
    logic [23:0] vid_addr;
    logic [31:0] vid_rdata;
    logic [23:0] sd_addr;
    logic        sd_we, sd_oe;
    logic [1:0]  sd_be;
    logic [15:0] sd_din, sd_dout;
    logic        grant, busy;

    logic [15:0] mem [0:1023];
    logic        pre_en;
    logic [9:0]  pre_idx;
    logic [15:0] pre_val;

    int n_cmp = 0;
    int n_err = 0;

    int          lat, n_oe, n_we, n_act;
    logic [23:0] a_first, a_last;
    logic [1:0]  be_first, be_last;
    logic [15:0] din_first, din_last;
    logic [31:0] rd;

    sdram_arbiter #(.SLOT_CYCLES(8), .ADDR_BITS(24)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
        .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .vid_valid(vid_valid), .vid_ready(vid_ready), .vid_addr(vid_addr),
        .vid_rdata(vid_rdata),
        .sd_addr(sd_addr), .sd_we(sd_we), .sd_oe(sd_oe), .sd_be(sd_be),
        .sd_din(sd_din), .sd_dout(sd_dout), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    assign sd_dout = mem[sd_addr[10:1]];

    // Memory model: preload port for the bench, byte-enabled writes from the DUT.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else if (sd_we) begin
            if (sd_be[0]) mem[sd_addr[10:1]][7:0]  <= sd_din[7:0];
            if (sd_be[1]) mem[sd_addr[10:1]][15:8] <= sd_din[15:8];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [23:0] byte_addr, input logic [15:0] val);
        pre_en  = 1'b1;
        pre_idx = byte_addr[10:1];
        pre_val = val;
        tick();
        pre_en  = 1'b0;
    endtask

    // One access on the chosen port; records slot activity and ready latency.
    task automatic access(input logic port, input logic [23:0] a, input logic [3:0] ws,
                          input logic [31:0] wd);
        if (!port) begin
            cpu_valid = 1'b1; cpu_addr = a; cpu_wstrb = ws; cpu_wdata = wd;
        end else begin
            vid_valid = 1'b1; vid_addr = a;
        end
        lat = 0; n_oe = 0; n_we = 0; n_act = 0; rd = 32'h0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 1) begin
                cpu_valid = 1'b0; vid_valid = 1'b0;
                cpu_wstrb = 4'b0000; cpu_wdata = 32'h0000_0000;
            end
            if (sd_oe || sd_we) begin
                if (n_act == 0) begin
                    a_first = sd_addr; be_first = sd_be; din_first = sd_din;
                end
                a_last = sd_addr; be_last = sd_be; din_last = sd_din;
                n_act++;
                if (sd_oe) n_oe++;
                if (sd_we) n_we++;
            end
            if (cpu_ready || vid_ready) begin
                lat = k;
                rd  = port ? vid_rdata : cpu_rdata;
                check("ready_port", {31'd0, vid_ready}, {31'd0, port});
                break;
            end
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    int ev_k [0:2];
    int ev_p [0:2];
    int n_ev;
    int n_rdy;

    initial begin
        resetn = 1'b0; cpu_valid = 1'b0; vid_valid = 1'b0;
        cpu_addr = 24'h0; vid_addr = 24'h0; cpu_wstrb = 4'h0; cpu_wdata = 32'h0;
        pre_en = 1'b0; pre_idx = 10'h0; pre_val = 16'h0;
        do_reset();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {31'd0, grant}, 32'd0);
        check("rst_oe_we", {30'd0, sd_oe, sd_we}, 32'd0);
        check("rst_ready", {30'd0, cpu_ready, vid_ready}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'h0);

        // CPU read
        preload(24'h100, 16'h1234);
        preload(24'h102, 16'hABCD);
        access(1'b0, 24'h000100, 4'b0000, 32'h0);
        check("rd_lat", lat, 32'd17);
        check("rd_oe_cycles", n_oe, 32'd16);
        check("rd_we_cycles", n_we, 32'd0);
        check("rd_addr_lo", {8'd0, a_first}, 32'h100);
        check("rd_addr_hi", {8'd0, a_last}, 32'h102);
        check("rd_be", {30'd0, be_first}, 32'd3);
        check("rd_data", rd, 32'hABCD1234);
        tick();
        check("ready_width", {31'd0, cpu_ready}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);

        // Full write, then read it back
        access(1'b0, 24'h000200, 4'b1111, 32'hDEADBEEF);
        check("fw_lat", lat, 32'd17);
        check("fw_we_cycles", n_we, 32'd16);
        check("fw_din_lo", {16'd0, din_first}, 32'hBEEF);
        check("fw_din_hi", {16'd0, din_last}, 32'hDEAD);
        check("fw_addr_lo", {8'd0, a_first}, 32'h200);
        check("fw_addr_hi", {8'd0, a_last}, 32'h202);
        check("fw_be", {28'd0, be_first, be_last}, 32'hF);
        tick();
        access(1'b0, 24'h000200, 4'b0000, 32'h0);
        check("fw_readback", rd, 32'hDEADBEEF);
        tick();

        // Single-half writes
        access(1'b0, 24'h000300, 4'b0100, 32'h11223344);
        check("hw_hi_lat", lat, 32'd9);
        check("hw_hi_we_cycles", n_we, 32'd8);
        check("hw_hi_addr", {8'd0, a_first}, 32'h302);
        check("hw_hi_be", {30'd0, be_first}, 32'd1);
        check("hw_hi_din", {16'd0, din_first}, 32'h1122);
        tick();
        access(1'b0, 24'h000304, 4'b0001, 32'h11223344);
        check("hw_lo_lat", lat, 32'd9);
        check("hw_lo_we_cycles", n_we, 32'd8);
        check("hw_lo_addr", {8'd0, a_first}, 32'h304);
        check("hw_lo_be", {30'd0, be_first}, 32'd1);
        check("hw_lo_din", {16'd0, din_first}, 32'h3344);
        tick();
        check("hw_mem_hi", {16'd0, mem[24'h302 >> 1]}, 32'h0022);
        check("hw_mem_lo", {16'd0, mem[24'h304 >> 1]}, 32'h0044);

        // Simultaneous requests after reset: CPU, VID, CPU
        do_reset();
        cpu_valid = 1'b1; cpu_addr = 24'h100; cpu_wstrb = 4'b0000;
        vid_valid = 1'b1; vid_addr = 24'h200;
        n_ev = 0;
        for (int k = 1; k <= 120 && n_ev < 3; k++) begin
            tick();
            if (k == 1) check("tie_first_grant", {31'd0, grant}, 32'd0);
            if (cpu_ready || vid_ready) begin
                ev_k[n_ev] = k;
                ev_p[n_ev] = vid_ready ? 1 : 0;
                n_ev++;
            end
        end
        cpu_valid = 1'b0; vid_valid = 1'b0;
        check("tie_events", n_ev, 32'd3);
        check("tie_order", {29'd0, ev_p[0][0], ev_p[1][0], ev_p[2][0]}, 32'b010);
        check("tie_k0", ev_k[0], 32'd17);
        check("tie_k1", ev_k[1], 32'd35);
        check("tie_k2", ev_k[2], 32'd53);
        tick();
        tick();

        // Video read with valid dropped during LO
        preload(24'h400, 16'h5678);
        preload(24'h402, 16'h9ABC);
        access(1'b1, 24'h000402, 4'b0000, 32'h0);
        check("vid_lat", lat, 32'd17);
        check("vid_data", rd, 32'h9ABC5678);
        check("vid_grant", {31'd0, grant}, 32'd1);
        tick();

        // Reset during HI aborts without a ready pulse
        cpu_valid = 1'b1; cpu_addr = 24'h100; cpu_wstrb = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) cpu_valid = 1'b0;
        end
        check("abort_in_hi_oe", {31'd0, sd_oe}, 32'd1);
        check("abort_in_hi_addr", {8'd0, sd_addr}, 32'h102);
        resetn = 1'b0;
        tick();
        check("abort_oe", {31'd0, sd_oe}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        resetn = 1'b1;
        n_rdy = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (cpu_ready || vid_ready) n_rdy++;
        end
        check("abort_no_ready", n_rdy, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter and sequencer for the 16-bit SDRAM controller. It shares the controller between the CPU data/instruction bus and a read-only video fetch port. It splits each 32-bit word access into one or two 16-bit half-word slots of fixed length and returns a single-cycle ready to the granted requester. It sits between the SoC bus decode and the `sdram` controller instance, and replaces ad-hoc per-port cycle counting.

## Interface

Parameters:
- `SLOT_CYCLES`, 8: clk cycles per 16-bit sub-access; power of two, ≥ 2.
- `ADDR_BITS`, 24: byte-address width on all address ports.

Ports:
- `clk` in 1: single clock; the SDRAM controller's `clkref` domain.
- `resetn` in 1: synchronous, active-low reset.
- `cpu_valid` in 1: CPU request.
- `cpu_ready` out 1: one-cycle completion pulse to the CPU.
- `cpu_addr` in ADDR_BITS: CPU byte address; bits [1:0] are ignored.
- `cpu_wstrb` in 4: byte write strobes; 0 means read.
- `cpu_wdata` in 32: write data.
- `cpu_rdata` out 32: read data; valid while `cpu_ready` is high.
- `vid_valid` in 1: video fetch request (always a read).
- `vid_ready` out 1: one-cycle completion pulse to video.
- `vid_addr` in ADDR_BITS: video byte address; bits [1:0] are ignored.
- `vid_rdata` out 32: read data; valid while `vid_ready` is high.
- `sd_addr` out ADDR_BITS: half-word byte address to the controller.
- `sd_we` out 1: write enable for the current slot.
- `sd_oe` out 1: read enable for the current slot.
- `sd_be` out 2: byte enables, active high, for the current slot.
- `sd_din` out 16: write half-word.
- `sd_dout` in 16: read half-word from the controller.
- `grant` out 1: owner of the current or last access; 0 = CPU, 1 = video.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation

- FSM states: IDLE, LO, HI, DONE. Slot counter `cnt` is log2(SLOT_CYCLES) bits.
- **IDLE**
  - If only one `*_valid` is high, that port is granted.
  - If both are high, the port not equal to `last` is granted (round-robin).
  - On grant, latch the word address, the strobes (forced to 0 for video) and the wdata; set `last`/`grant`.
  - Next state: LO, unless this is a write with `wstrb[1:0]==0`, in which case go straight to HI.
- **LO**
  - `sd_addr` = {addr[ADDR_BITS-1:2], 2'b00}.
  - Read: `sd_oe`=1, `sd_be`=11. Write: `sd_we`=1, `sd_be`=wstrb[1:0], `sd_din`=wdata[15:0].
  - When `cnt`==SLOT_CYCLES-1: a read captures `sd_dout` into rdata[15:0]. Next state is HI, unless this is a write with `wstrb[3:2]==0`, in which case go to DONE.
- **HI**
  - Same as LO, using {addr[..:2], 2'b10}, wstrb[3:2] and wdata[31:16].
  - At the last count: a read captures rdata[31:16]. Next state: DONE.
- **DONE**
  - Pulse the granted port's ready for one cycle; the shared rdata register drives both `cpu_rdata` and `vid_rdata`.
  - Next state: IDLE.
- `cnt` clears on entry to LO and to HI.
- `sd_we`, `sd_oe` and `sd_be` are 0 in IDLE and DONE.
- A `*_valid` that drops mid-access does not abort: the SDRAM access completes and the ready pulse still fires (the requester ignores it).
- Inputs of the non-granted port are ignored until the FSM returns to IDLE.
- A requester that keeps valid high after its ready pulse is re-arbitrated as a new request.
- `cpu_wstrb`/`cpu_wdata` changes after the grant have no effect; the latched values are used.

## Timing

- All outputs are registered.
- Reset values: state=IDLE, `cnt`=0, `last`=1 (so the CPU wins the first tie), `grant`=0, rdata=0, all `sd_*`=0, both ready=0, `busy`=0.
- `resetn` low in any state returns the FSM to IDLE on the next edge. No ready pulse is emitted for an aborted access, and `sd_we`/`sd_oe` are low from that edge.
- With S = SLOT_CYCLES and grant decided in IDLE at cycle t:
  - LO occupies cycles t+1 … t+S.
  - HI occupies cycles t+S+1 … t+2S.
  - ready is high at t+2S+1.
- Read, or write touching both halves: ready at t+2S+1 (t+17 for S=8).
- Single-half write: ready at t+S+1.
- Back-to-back accesses: the next grant is no earlier than the cycle after DONE, so minimum spacing is 2S+2 cycles per full word.
- `sd_addr`, `sd_be` and `sd_din` are stable for the full S cycles of a slot.
- `sd_dout` is sampled only on the last cycle of a read slot.

## Test plan

- **CPU read:** preload SDRAM model 0x1234 at byte 0x100 and 0xABCD at 0x102; `cpu_valid`, addr 0x100, wstrb 0 → `sd_oe` high for 16 cycles (addr 0x100 then 0x102), `cpu_ready` at t+17, `cpu_rdata` = 0xABCD1234.
- **Full write:** wstrb 1111, wdata 0xDEADBEEF, addr 0x200 → slot 1 has `sd_din` 0xBEEF, be 11; slot 2 has `sd_din` 0xDEAD at 0x202; ready at t+17.
- **Single-half writes:** wstrb 0100 → only a HI slot with be 01, ready at t+9. Wstrb 0001 → only a LO slot, ready at t+9.
- **Simultaneous requests after reset:** CPU granted first (`grant`=0); video granted next; with both held high, grants alternate CPU, VID, CPU.
- **Mid-access events:** `vid_valid` dropped during LO → access completes, `vid_ready` still pulses. `resetn` low during HI → next edge state IDLE, `sd_oe`=0, no ready pulse.
- **Ready width:** `cpu_ready` held for exactly 1 cycle; `busy` low in the cycle after DONE.
